ace_master_port: RTL and testbench

Bus-side counterpart to the cache controller: accepts one coherent request at a time (line fill, write-back, or ownership upgrade) and executes it as a single-beat ACE transaction on the AR/R or AW/W/B channels. It generates RACK/WACK, returns the fill line plus snoop-result bits for the controller's next-state logic, and pulses `ace_ready` on completion. It sits between the cache controller and the interconnect.

---
 rtl/ace_master_port.sv | 250 +++++++++++++++++++++++++
 tb/tb_ace_master_port.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_master_port.sv
// ace_master_port
// Executes one coherent cache request at a time as a single-beat ACE
// transaction:
//   - line fills use AR/R (ReadShared or ReadUnique);
//   - upgrades use AR/R (CleanUnique);
//   - write-backs use AW/W/B (WriteBack).
//
// Port summary
//   clk, rst                       clock, asynchronous active-high reset
//   read_req/write_req/invalid_req request from the cache controller, held
//                                  until ace_ready
//   req_unique, req_addr, wb_data  request qualifiers, latched on acceptance
//   ace_ready                      one-cycle completion pulse
//   rd_data                        fill data, updated only by completed fills
//   rd_shared, rd_dirty            captured RRESP[3] / RRESP[2]
//   resp_err                       captured error from RRESP[1:0] or BRESP
//   ar*/r*/aw*/w*/b*, rack, wack   ACE master channels
module ace_master_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic                  req_unique,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  ace_ready,
  output logic [LINE_WIDTH-1:0] rd_data,
  output logic                  rd_shared,
  output logic                  rd_dirty,
  output logic                  resp_err,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arsnoop,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [LINE_WIDTH-1:0] rdata,
  input  logic [3:0]            rresp,
  output logic                  rack,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsnoop,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [LINE_WIDTH-1:0] wdata,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  wack
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AR_SEND   = 3'd1,
    R_WAIT    = 3'd2,
    R_ACK     = 3'd3,
    AW_W_SEND = 3'd4,
    B_WAIT    = 3'd5,
    W_ACK     = 3'd6
  } state_t;

  localparam logic [3:0] SNOOP_READ_SHARED  = 4'b0001;
  localparam logic [3:0] SNOOP_READ_UNIQUE  = 4'b0111;
  localparam logic [3:0] SNOOP_CLEAN_UNIQUE = 4'b1011;
  localparam logic [2:0] SNOOP_WRITE_BACK   = 3'b011;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_aw_fin;
  logic                  w_w_fin;

  logic                  r_ace_ready;
  logic [LINE_WIDTH-1:0] r_rd_data;
  logic                  r_rd_shared;
  logic                  r_rd_dirty;
  logic                  r_resp_err;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [3:0]            r_arsnoop;
  logic                  r_rready;
  logic                  r_rack;
  logic                  r_awvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [2:0]            r_awsnoop;
  logic                  r_wvalid;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_bready;
  logic                  r_wack;
  // Set for line fills; CleanUnique must not overwrite rd_data.
  logic                  r_fill;

  // Each write channel is finished once its VALID has already dropped or
  // it completes its handshake this cycle.
  assign w_aw_fin = !r_awvalid || awready;
  assign w_w_fin  = !r_wvalid  || wready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. write_req takes priority so the victim write-back
  // goes out ahead of the refill.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (write_req) begin
          w_state_next = AW_W_SEND;
        end else if (read_req || invalid_req) begin
          w_state_next = AR_SEND;
        end else begin
          w_state_next = IDLE;
        end
      end
      AR_SEND: begin
        if (arready) w_state_next = R_WAIT;
        else         w_state_next = AR_SEND;
      end
      R_WAIT: begin
        if (rvalid) w_state_next = R_ACK;
        else        w_state_next = R_WAIT;
      end
      R_ACK: w_state_next = IDLE;
      AW_W_SEND: begin
        if (w_aw_fin && w_w_fin) w_state_next = B_WAIT;
        else                     w_state_next = AW_W_SEND;
      end
      B_WAIT: begin
        if (bvalid) w_state_next = W_ACK;
        else        w_state_next = B_WAIT;
      end
      W_ACK:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Registered channel controls, latched request fields and captured responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ace_ready <= 1'b0;
      r_rd_data   <= '0;
      r_rd_shared <= 1'b0;
      r_rd_dirty  <= 1'b0;
      r_resp_err  <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arsnoop   <= 4'b0000;
      r_rready    <= 1'b0;
      r_rack      <= 1'b0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_awsnoop   <= 3'b000;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_bready    <= 1'b0;
      r_wack      <= 1'b0;
      r_fill      <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses.
      r_ace_ready <= 1'b0;
      r_rack      <= 1'b0;
      r_wack      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (write_req) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= req_addr;
            r_wdata   <= wb_data;
            r_awsnoop <= SNOOP_WRITE_BACK;
          end else if (read_req) begin
            r_arvalid <= 1'b1;
            r_araddr  <= req_addr;
            r_arsnoop <= req_unique ? SNOOP_READ_UNIQUE : SNOOP_READ_SHARED;
            r_fill    <= 1'b1;
          end else if (invalid_req) begin
            r_arvalid <= 1'b1;
            r_araddr  <= req_addr;
            r_arsnoop <= SNOOP_CLEAN_UNIQUE;
            r_fill    <= 1'b0;
          end else begin
            r_fill <= r_fill;
          end
        end
        AR_SEND: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_rd_shared <= rresp[3];
            r_rd_dirty  <= rresp[2];
            r_resp_err  <= |rresp[1:0];
            if (r_fill) r_rd_data <= rdata;
            r_rack      <= 1'b1;
            r_ace_ready <= 1'b1;
          end
        end
        AW_W_SEND: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_fin && w_w_fin) r_bready <= 1'b1;
        end
        B_WAIT: begin
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_resp_err  <= |bresp;
            r_wack      <= 1'b1;
            r_ace_ready <= 1'b1;
          end
        end
        default: begin
          r_fill <= r_fill;
        end
      endcase
    end
  end

  assign ace_ready = r_ace_ready;
  assign rd_data   = r_rd_data;
  assign rd_shared = r_rd_shared;
  assign rd_dirty  = r_rd_dirty;
  assign resp_err  = r_resp_err;
  assign arvalid   = r_arvalid;
  assign araddr    = r_araddr;
  assign arsnoop   = r_arsnoop;
  assign rready    = r_rready;
  assign rack      = r_rack;
  assign awvalid   = r_awvalid;
  assign awaddr    = r_awaddr;
  assign awsnoop   = r_awsnoop;
  assign wvalid    = r_wvalid;
  assign wdata     = r_wdata;
  assign bready    = r_bready;
  assign wack      = r_wack;

endmodule

// File: tb/tb_ace_master_port.sv
// Bench for ace_master_port: a delay-configurable ACE slave responds on the
// negative edge, a scoreboard checks every completion, a vector table covers
// the main request kinds, and hand-written sequences cover request priority
// and reset in the middle of a transaction.
module tb_ace_master_port;

  logic         clk, rst;
  logic         read_req, write_req, invalid_req, req_unique;
  logic [31:0]  req_addr;
  logic [127:0] wb_data;
  logic         ace_ready, rd_shared, rd_dirty, resp_err;
  logic [127:0] rd_data;
  logic         arvalid, arready, rvalid, rready, rack;
  logic [31:0]  araddr, awaddr;
  logic [3:0]   arsnoop, rresp;
  logic [127:0] rdata, wdata;
  logic         awvalid, awready, wvalid, wready, bvalid, bready, wack;
  logic [2:0]   awsnoop;
  logic [1:0]   bresp;

  ace_master_port #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .req_unique(req_unique), .req_addr(req_addr), .wb_data(wb_data),
    .ace_ready(ace_ready), .rd_data(rd_data), .rd_shared(rd_shared),
    .rd_dirty(rd_dirty), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsnoop(arsnoop),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rack(rack),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsnoop(awsnoop),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .wack(wack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 ReadShared, 1 ReadUnique, 2 CleanUnique, 3 WriteBack
  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;   // rdata for reads, wb_data for writes
    logic [3:0]   resp;   // rresp, or bresp in [1:0]
    int           d_a;    // AR or AW ready delay
    int           d_w;    // W ready delay
    int           d_rb;   // R or B valid delay
    bit           early;  // drive garbage rvalid during AR_SEND
    logic [3:0]   snoop;
    logic [127:0] exp_rd;
    logic         exp_sh, exp_dr, exp_err;
    int           lat;
  } vec_t;

  typedef struct {
    logic         is_rd;
    logic [127:0] rd;
    logic         sh, dr, err;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // slave configuration and observations
  int           cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  bit           cfg_early = 1'b0;
  logic [127:0] cfg_rdata = '0;
  logic [3:0]   cfg_rresp = 4'b0000;
  logic [1:0]   cfg_bresp = 2'b00;
  int           ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_hs = 0;
  logic [31:0]  ar_first, got_araddr, got_awaddr;
  logic [3:0]   got_arsnoop;
  logic [2:0]   got_awsnoop;
  logic [127:0] got_wdata;
  bit           ar_unstable = 1'b0, rready_bad = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ACE slave: decides READY/VALID at the negative edge from DUT outputs.
  always @(negedge clk) begin
    if (rst) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (arvalid) begin
        if (ar_cnt == 0) ar_first = araddr;
        else if (araddr !== ar_first) ar_unstable = 1'b1;
        if (rready) rready_bad = 1'b1;
        arready = (ar_cnt == cfg_ar);
        if (arready) begin
          got_araddr = araddr; got_arsnoop = arsnoop; ar_hs++;
        end
        ar_cnt++;
      end else begin
        arready = 1'b0; ar_cnt = 0;
      end
      if (rready) begin
        rvalid = (r_cnt == cfg_r); rdata = cfg_rdata; rresp = cfg_rresp; r_cnt++;
      end else begin
        r_cnt = 0;
        if (cfg_early && arvalid) begin
          rvalid = 1'b1; rdata = ~cfg_rdata; rresp = 4'b0011;
        end else begin
          rvalid = 1'b0;
        end
      end
      if (awvalid) begin
        awready = (aw_cnt == cfg_aw);
        if (awready) begin
          got_awaddr = awaddr; got_awsnoop = awsnoop;
        end
        aw_cnt++;
      end else begin
        awready = 1'b0; aw_cnt = 0;
      end
      if (wvalid) begin
        wready = (w_cnt == cfg_w);
        if (wready) got_wdata = wdata;
        w_cnt++;
      end else begin
        wready = 1'b0; w_cnt = 0;
      end
      if (bready) begin
        bvalid = (b_cnt == cfg_b); bresp = cfg_bresp; b_cnt++;
      end else begin
        bvalid = 1'b0; b_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every ace_ready pulse consumes one expectation.
  always @(posedge clk) begin
    #1;
    if (ace_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ace_ready: got 1 expected 0");
      end else begin
        mon_e = sb_q.pop_front();
        chk("rd_data",   rd_data,   mon_e.rd);
        chk("rd_shared", rd_shared, mon_e.sh);
        chk("rd_dirty",  rd_dirty,  mon_e.dr);
        chk("resp_err",  resp_err,  mon_e.err);
        chk("rack",      rack,      mon_e.is_rd);
        chk("wack",      wack,      !mon_e.is_rd);
      end
    end
  end

  task automatic wait_ready(output int lat);
    bit got;
    lat = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      got = (ace_ready === 1'b1);
    end
  endtask

  task automatic all_outputs_zero(input string nm);
    logic any;
    any = |{ace_ready, rd_data, rd_shared, rd_dirty, resp_err, arvalid, araddr,
            arsnoop, rready, rack, awvalid, awaddr, awsnoop, wvalid, wdata,
            bready, wack};
    chk(nm, any, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    exp_t e;
    @(negedge clk);
    cfg_ar = v.d_a; cfg_aw = v.d_a; cfg_w = v.d_w; cfg_r = v.d_rb; cfg_b = v.d_rb;
    cfg_early = v.early; cfg_rdata = v.data; cfg_rresp = v.resp; cfg_bresp = v.resp[1:0];
    ar_unstable = 1'b0; rready_bad = 1'b0;
    req_addr = v.addr; wb_data = v.data; req_unique = (v.kind == 1);
    read_req = (v.kind == 0 || v.kind == 1);
    invalid_req = (v.kind == 2);
    write_req = (v.kind == 3);
    e.is_rd = (v.kind != 3); e.rd = v.exp_rd; e.sh = v.exp_sh; e.dr = v.exp_dr; e.err = v.exp_err;
    sb_q.push_back(e);
    wait_ready(lat);
    n_vec++;
    chk("latency", lat, v.lat);
    if (v.kind == 3) begin
      chk("awaddr", got_awaddr, v.addr);
      chk("awsnoop", {1'b0, got_awsnoop}, v.snoop);
      chk("wdata", got_wdata, v.data);
    end else begin
      chk("araddr", got_araddr, v.addr);
      chk("arsnoop", got_arsnoop, v.snoop);
      chk("ar_stable", ar_unstable, 1'b0);
      chk("rready_in_ar_send", rready_bad, 1'b0);
    end
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    cfg_early = 1'b0;
  endtask

  localparam logic [127:0] D0  = {16{8'hA5}};
  localparam logic [127:0] D1  = {4{32'h1111_2222}};
  localparam logic [127:0] D2  = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] D3  = {16{8'hFF}};
  localparam logic [127:0] D4  = {4{32'h0404_0404}};
  localparam logic [127:0] D5  = {4{32'h5555_0000}};
  localparam logic [127:0] D6  = {2{64'h0123_4567_89AB_CDEF}};
  localparam logic [127:0] D7  = {4{32'h7777_AAAA}};
  localparam logic [127:0] D66 = {4{32'h6666_6666}};
  localparam logic [127:0] D77 = {4{32'h7070_7070}};
  localparam logic [127:0] D99 = {4{32'h9999_9999}};
  localparam logic [127:0] D88 = {4{32'h8888_1234}};

  vec_t vecs[8];
  vec_t vpost;

  initial begin
    int lat, hs0;
    exp_t e;
    // kind addr data resp d_a d_w d_rb early snoop exp_rd sh dr err lat
    vecs[0] = '{0, 32'h0000_1000, D0, 4'b1000, 0, 0, 0, 1'b0, 4'b0001, D0, 1'b1, 1'b0, 1'b0, 3};
    vecs[1] = '{3, 32'h0000_2000, D1, 4'b0000, 0, 3, 1, 1'b0, 4'b0011, D0, 1'b1, 1'b0, 1'b0, 7};
    vecs[2] = '{1, 32'h0000_3040, D2, 4'b0100, 2, 0, 1, 1'b0, 4'b0111, D2, 1'b0, 1'b1, 1'b0, 6};
    vecs[3] = '{2, 32'h0000_3040, D3, 4'b0010, 0, 0, 0, 1'b0, 4'b1011, D2, 1'b0, 1'b0, 1'b1, 3};
    vecs[4] = '{0, 32'h0000_4000, D4, 4'b1100, 5, 0, 0, 1'b1, 4'b0001, D4, 1'b1, 1'b1, 1'b0, 8};
    vecs[5] = '{3, 32'h0000_5000, D5, 4'b0010, 0, 0, 0, 1'b0, 4'b0011, D4, 1'b1, 1'b1, 1'b1, 3};
    vecs[6] = '{0, 32'h0000_6000, D6, 4'b0001, 0, 0, 3, 1'b0, 4'b0001, D6, 1'b0, 1'b0, 1'b1, 6};
    vecs[7] = '{3, 32'h0000_7000, D7, 4'b0000, 2, 0, 2, 1'b0, 4'b0011, D6, 1'b0, 1'b0, 1'b0, 7};
    vpost   = '{0, 32'h0000_8000, D88, 4'b1000, 0, 0, 0, 1'b0, 4'b0001, D88, 1'b1, 1'b0, 1'b0, 3};

    rst = 1'b1; read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    req_unique = 1'b0; req_addr = '0; wb_data = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 4'b0000;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    all_outputs_zero("reset_state");
    n_vec++;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // write_req and read_req together: write-back first, then the read
    // with the address the requester presents afterwards.
    @(negedge clk);
    cfg_ar = 0; cfg_aw = 0; cfg_w = 0; cfg_r = 0; cfg_b = 0;
    cfg_rdata = D77; cfg_rresp = 4'b0000; cfg_bresp = 2'b00;
    req_addr = 32'h0000_A000; wb_data = D66; req_unique = 1'b0;
    write_req = 1'b1; read_req = 1'b1;
    e.is_rd = 1'b0; e.rd = D6; e.sh = 1'b0; e.dr = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    hs0 = ar_hs;
    wait_ready(lat);
    n_vec++;
    chk("prio_write_first", wack, 1'b1);
    chk("prio_no_ar_yet", ar_hs, hs0);
    chk("prio_awaddr", got_awaddr, 32'h0000_A000);
    chk("prio_wdata", got_wdata, D66);
    @(negedge clk);
    write_req = 1'b0; req_addr = 32'h0000_B000;
    e.is_rd = 1'b1; e.rd = D77; e.sh = 1'b0; e.dr = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    wait_ready(lat);
    n_vec++;
    chk("prio_read_done", rack, 1'b1);
    chk("prio_araddr", got_araddr, 32'h0000_B000);
    chk("prio_read_latency", lat, 4);
    @(negedge clk);
    read_req = 1'b0;

    // reset asserted while waiting for the write response
    @(negedge clk);
    cfg_aw = 0; cfg_w = 0; cfg_b = 5;
    req_addr = 32'h0000_9000; wb_data = D99; write_req = 1'b1;
    lat = 0;
    while (bready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    chk("reach_b_wait", bready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    all_outputs_zero("reset_in_b_wait");
    @(negedge clk);
    rst = 1'b0; write_req = 1'b0;
    #1;
    all_outputs_zero("after_reset_idle");
    run_vec(vpost);

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
